ro_puf_sequencer: RTL and testbench

- Controller for the ring-oscillator PUF array. It takes a challenge and start request, then enables each oscillator one at a time.
- For each oscillator it gates the shared edge counter for a fixed CLK-domain window and captures the count. After the last oscillator it compares adjacent counts and returns the response word with a done pulse.
- Sits between the switch/button front end and the RingOsc instances plus their shared counter.

---
 rtl/ro_puf_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_ro_puf_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF sequencer: enables each RO in turn, gates the shared counter for a CLK window, compares adjacent counts.
// Latency: 3 + NUM_RO*(2 + 2*SETTLE_CYCLES + WINDOW_CYCLES) cycles from start to done; start ignored while busy. Optional macro PUF_WEAK_BIT_EN adds resp_weak.
module ro_puf_sequencer #(
    parameter int NUM_RO        = 9,
    parameter int CHAL_W        = 6,
    parameter int CNT_W         = 32,
    parameter int WINDOW_CYCLES = 10000000,
    parameter int SETTLE_CYCLES = 4
`ifdef PUF_WEAK_BIT_EN
    ,
    parameter int WEAK_THRESH   = 16
`endif
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      start,
    input  logic [CHAL_W-1:0]         challenge,
    output logic [CHAL_W-1:0]         chal_out,
    output logic [NUM_RO-1:0]         ro_enable,
    output logic [$clog2(NUM_RO)-1:0] ro_index,
    output logic                      cnt_clear,
    output logic                      cnt_run,
    input  logic [CNT_W-1:0]          cnt_value,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_RO-2:0]         response
`ifdef PUF_WEAK_BIT_EN
    ,
    output logic [NUM_RO-2:0]         resp_weak
`endif
);

    localparam int IDX_W   = $clog2(NUM_RO);
    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_SETTLE_ON, S_MEASURE, S_SETTLE_OFF, S_STORE, S_COMP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic [NUM_RO-1:0]   ro_enable_q, ro_enable_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                cnt_clear_q, cnt_clear_d;
    logic                cnt_run_q, cnt_run_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [NUM_RO-2:0]   response_q, response_d;
    logic [CNT_W-1:0]    count_q [NUM_RO];
    logic [CNT_W-1:0]    count_d [NUM_RO];
    logic [NUM_RO-1:0]   one_hot0;

    assign one_hot0 = {{(NUM_RO-1){1'b0}}, 1'b1};

`ifdef PUF_WEAK_BIT_EN
    logic [NUM_RO-2:0]   weak_q, weak_d;

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] ea;
        logic [CNT_W:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        tmr_d       = '0;
        chal_d      = chal_q;
        ro_enable_d = ro_enable_q;
        idx_d       = idx_q;
        cnt_clear_d = 1'b0;
        cnt_run_d   = cnt_run_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        response_d  = response_q;
        count_d     = count_q;
`ifdef PUF_WEAK_BIT_EN
        weak_d      = weak_q;
`endif
        // Outputs are computed for the state being entered so they are registered in that state.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chal_d      = challenge;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    ro_enable_d = one_hot0;
                    cnt_clear_d = 1'b1;
                    state_d     = S_ARM;
                end
            end
            S_ARM: state_d = S_SETTLE_ON;
            S_SETTLE_ON: begin
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    cnt_run_d = 1'b1;
                    state_d   = S_MEASURE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_MEASURE: begin
                if (tmr_q == TMR_W'(WINDOW_CYCLES - 1)) begin
                    cnt_run_d = 1'b0;
                    state_d   = S_SETTLE_OFF;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_SETTLE_OFF: begin
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_STORE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_STORE: begin
                count_d[idx_q] = cnt_value;
                if (idx_q != IDX_W'(NUM_RO - 1)) begin
                    idx_d       = idx_q + IDX_W'(1);
                    ro_enable_d = one_hot0 << (idx_q + IDX_W'(1));
                    cnt_clear_d = 1'b1;
                    state_d     = S_ARM;
                end else begin
                    ro_enable_d = '0;
                    state_d     = S_COMP;
                end
            end
            S_COMP: begin
                for (int i = 0; i < NUM_RO - 1; i++) begin
                    response_d[i] = (count_q[i] >= count_q[i+1]);
`ifdef PUF_WEAK_BIT_EN
                    weak_d[i] = (abs_diff(count_q[i], count_q[i+1]) < (CNT_W+1)'(WEAK_THRESH));
`endif
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            chal_q      <= '0;
            ro_enable_q <= '0;
            idx_q       <= '0;
            cnt_clear_q <= 1'b0;
            cnt_run_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            response_q  <= '0;
            for (int k = 0; k < NUM_RO; k++) count_q[k] <= '0;
`ifdef PUF_WEAK_BIT_EN
            weak_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            chal_q      <= chal_d;
            ro_enable_q <= ro_enable_d;
            idx_q       <= idx_d;
            cnt_clear_q <= cnt_clear_d;
            cnt_run_q   <= cnt_run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            response_q  <= response_d;
            for (int k = 0; k < NUM_RO; k++) count_q[k] <= count_d[k];
`ifdef PUF_WEAK_BIT_EN
            weak_q      <= weak_d;
`endif
        end
    end

    assign chal_out  = chal_q;
    assign ro_enable = ro_enable_q;
    assign ro_index  = idx_q;
    assign cnt_clear = cnt_clear_q;
    assign cnt_run   = cnt_run_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign response  = response_q;
`ifdef PUF_WEAK_BIT_EN
    assign resp_weak = weak_q;
`endif

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Bench for ro_puf_sequencer: table-driven count patterns, random counts against a reference model, and start/reset corner cases.
module tb_ro_puf_sequencer;

    localparam int N  = 9;
    localparam int CW = 6;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int LAT = 3 + N * (2 + 2 * S + W);

    logic          CLK;
    logic          RST_N;
    logic          start;
    logic [CW-1:0] challenge;
    logic [CW-1:0] chal_out;
    logic [N-1:0]  ro_enable;
    logic [3:0]    ro_index;
    logic          cnt_clear;
    logic          cnt_run;
    logic [31:0]   cnt_value;
    logic          busy;
    logic          done;
    logic [N-2:0]  response;
`ifdef PUF_WEAK_BIT_EN
    logic [N-2:0]  resp_weak;
`endif

    logic [31:0] vals [N];
    int errors = 0;
    int checks = 0;

    ro_puf_sequencer #(
        .NUM_RO(N), .CHAL_W(CW), .CNT_W(32), .WINDOW_CYCLES(W), .SETTLE_CYCLES(S)
`ifdef PUF_WEAK_BIT_EN
        , .WEAK_THRESH(16)
`endif
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .challenge(challenge),
        .chal_out(chal_out), .ro_enable(ro_enable), .ro_index(ro_index),
        .cnt_clear(cnt_clear), .cnt_run(cnt_run), .cnt_value(cnt_value),
        .busy(busy), .done(done), .response(response)
`ifdef PUF_WEAK_BIT_EN
        , .resp_weak(resp_weak)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shared counter stand-in: presents the programmed count of whichever RO is selected.
    always_comb cnt_value = (ro_index < 4'(N)) ? vals[ro_index] : 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-2:0] ref_resp();
        logic [N-2:0] r;
        for (int i = 0; i < N - 1; i++) r[i] = (vals[i] >= vals[i+1]);
        return r;
    endfunction

    function automatic logic [N-2:0] ref_weak();
        logic [N-2:0] r;
        longint d;
        for (int i = 0; i < N - 1; i++) begin
            d = longint'(vals[i]) - longint'(vals[i+1]);
            if (d < 0) d = -d;
            r[i] = (d < 16);
        end
        return r;
    endfunction

    task automatic do_run(input logic [CW-1:0] ch, input logic [N-2:0] exp_resp, input string name);
        int cyc = 2;
        int done_at = 0;
        int run_cyc = 0;
        int clr_cnt = 0;
        int bad_hot = 0;
        int chal_bad = 0;
        int busy_bad = 0;
        int seq_ok;
        logic [N-1:0] last = '0;
        logic [N-1:0] seq [$];
        @(negedge CLK);
        challenge = ch;
        start     = 1'b1;
        @(posedge CLK); #1;
        start     = 1'b0;
        challenge = ~ch;
        while (cyc < LAT + 50 && done_at == 0) begin
            if ($countones(ro_enable) > 1) bad_hot++;
            if (cnt_run && ro_enable == '0) bad_hot++;
            if (ro_enable != '0 && ro_enable != last) seq.push_back(ro_enable);
            last = ro_enable;
            if (cnt_run) run_cyc++;
            if (cnt_clear) clr_cnt++;
            if (chal_out != ch) chal_bad++;
            if (done) done_at = cyc;
            else if (!busy) busy_bad++;
            if (done_at == 0) begin
                @(posedge CLK); #1;
                cyc++;
            end
        end
        seq_ok = (seq.size() == N);
        for (int k = 0; k < seq.size(); k++)
            if (seq[k] != (N'(1) << k)) seq_ok = 0;
        chk({name, "_done_cycle"}, 64'(done_at), 64'(LAT));
        chk({name, "_response"}, 64'(response), 64'(exp_resp));
        chk({name, "_busy_at_done"}, 64'(busy), 64'(0));
        chk({name, "_onehot"}, 64'(bad_hot), 64'(0));
        chk({name, "_enable_seq"}, 64'(seq_ok), 64'(1));
        chk({name, "_run_cycles"}, 64'(run_cyc), 64'(N * W));
        chk({name, "_clears"}, 64'(clr_cnt), 64'(N));
        chk({name, "_chal_out"}, 64'(chal_bad), 64'(0));
        chk({name, "_busy_held"}, 64'(busy_bad), 64'(0));
        @(posedge CLK); #1;
        chk({name, "_after_done"}, {61'(0), done, busy, |ro_enable}, 64'(0));
        chk({name, "_resp_held"}, 64'(response), 64'(exp_resp));
    endtask

    typedef struct {
        int           base;
        int           step;
        logic [CW-1:0] ch;
        logic [N-2:0] exp_resp;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{base: 100, step: 10, ch: 6'h2A, exp_resp: 8'h00};
        vecs[1] = '{base: 500, step: -5, ch: 6'h15, exp_resp: 8'hFF};
        vecs[2] = '{base: 200, step: 0,  ch: 6'h3F, exp_resp: 8'hFF};
        vecs[3] = '{base: -1,  step: 0,  ch: 6'h01, exp_resp: 8'hFF};

        RST_N = 1'b0;
        start = 1'b0;
        challenge = '0;
        for (int k = 0; k < N; k++) vals[k] = '0;
        #12;
        chk("reset_outputs", {24'(0), chal_out, ro_enable, ro_index, cnt_clear, cnt_run, busy, done, response}, 64'(0));
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("idle_no_start", {61'(0), busy, done, cnt_run}, 64'(0));

        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < N; k++) vals[k] = 32'(vecs[v].base + vecs[v].step * k);
            do_run(vecs[v].ch, vecs[v].exp_resp, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < N; k++) vals[k] = $urandom_range(0, 40);
            do_run(6'($urandom), ref_resp(), $sformatf("rand%0d", r));
`ifdef PUF_WEAK_BIT_EN
            chk($sformatf("rand%0d_weak", r), 64'(resp_weak), 64'(ref_weak()));
`endif
        end

        // start held high with challenge changing mid-run
        begin
            int cyc = 2;
            int done_at = 0;
            int dones = 0;
            int chal_bad = 0;
            for (int k = 0; k < N; k++) vals[k] = 32'(300 - 3 * k);
            @(negedge CLK);
            challenge = 6'h2A;
            start = 1'b1;
            @(posedge CLK); #1;
            while (cyc < LAT + 50 && done_at == 0) begin
                if (cyc == 50) challenge = 6'h15;
                if (chal_out != 6'h2A) chal_bad++;
                if (done) begin done_at = cyc; dones++; end
                if (done_at == 0) begin @(posedge CLK); #1; cyc++; end
            end
            chk("held_done_cycle", 64'(done_at), 64'(LAT));
            chk("held_chal_stable", 64'(chal_bad), 64'(0));
            chk("held_response", 64'(response), 64'(ref_resp()));
            @(posedge CLK); #1;
            chk("held_idle_gap", {62'(0), busy, done}, 64'(0));
            @(posedge CLK); #1;
            chk("held_restart_busy", 64'(busy), 64'(1));
            chk("held_restart_chal", 64'(chal_out), 64'(6'h15));
            start = 1'b0;
        end

        // mid-run asynchronous reset during RO 4 measurement
        begin
            int found = 0;
            for (int c = 0; c < 2 * LAT && found == 0; c++) begin
                @(posedge CLK); #1;
                if (ro_enable == 9'h010 && cnt_run) found = 1;
            end
            chk("reach_ro4_measure", 64'(found), 64'(1));
            #2;
            RST_N = 1'b0;
            #1;
            chk("async_reset_outputs", {24'(0), chal_out, ro_enable, ro_index, cnt_clear, cnt_run, busy, done, response}, 64'(0));
            @(negedge CLK);
            RST_N = 1'b1;
        end
        for (int k = 0; k < N; k++) vals[k] = 32'(100 + 10 * k);
        do_run(6'h2A, 8'h00, "post_reset");

`ifdef PUF_WEAK_BIT_EN
        vals[0] = 1000;
        vals[1] = 1010;
        vals[2] = 1100;
        for (int k = 3; k < N; k++) vals[k] = 32'(1100 + 100 * (k - 2));
        do_run(6'h0C, 8'h00, "weak");
        chk("weak_bits", 64'(resp_weak), 64'(8'h01));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
